// File: rtl/xs3_to_bcd_rx.sv
// Serial Excess-3 receiver: shifts in 4-bit Excess-3 codes LSB first,
// subtracts 3 from each, packs NDIG digits into a BCD word (digit 0 in the
// low nibble) and flags any code outside 0011..1100.
//
// Handshake: a bit moves on an edge where in_valid && in_ready; a frame moves
// on an edge where out_valid && out_ready. in_ready is low while a completed
// frame is held, so no bit is ever consumed in that state.
module xs3_to_bcd_rx #(
    parameter int NDIG = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_bit,
    output logic              in_ready,
    output logic              out_valid,
    output logic [4*NDIG-1:0] out_bcd,
    output logic              out_err,
    input  logic              out_ready
);

    localparam int DW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic {
        RECV = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state;
    logic [1:0]        bit_cnt;
    logic [DW-1:0]     digit_cnt;
    logic [2:0]        sr;
    logic [4*NDIG-1:0] acc;
    logic              err_acc;

    logic [3:0]        code;
    logic              code_ok;
    logic [3:0]        digit_val;
    logic [4*NDIG-1:0] acc_next;
    logic              err_next;
    logic              last_digit;

    assign in_ready = (state == RECV);

    // Decode the code completed by the current bit and merge it into the accumulator.
    always_comb begin
        code       = {in_bit, sr};
        code_ok    = (code >= 4'd3) && (code <= 4'd12);
        digit_val  = code_ok ? (code - 4'd3) : 4'hF;
        err_next   = err_acc | ~code_ok;
        last_digit = (digit_cnt == DW'(NDIG - 1));
        acc_next   = acc;
        for (int k = 0; k < NDIG; k++) begin
            if (digit_cnt == DW'(k)) begin
                acc_next[4*k +: 4] = digit_val;
            end
        end
    end

    // Receive/hold state machine with registered frame outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RECV;
            bit_cnt   <= 2'd0;
            digit_cnt <= '0;
            sr        <= 3'd0;
            acc       <= '0;
            err_acc   <= 1'b0;
            out_valid <= 1'b0;
            out_bcd   <= '0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                RECV: begin
                    if (in_valid) begin
                        if (bit_cnt != 2'd3) begin
                            // Right shift so the first bit ends up in sr[0].
                            sr      <= {in_bit, sr[2:1]};
                            bit_cnt <= bit_cnt + 2'd1;
                        end else begin
                            bit_cnt <= 2'd0;
                            sr      <= 3'd0;
                            acc     <= acc_next;
                            err_acc <= err_next;
                            if (last_digit) begin
                                state     <= HOLD;
                                out_valid <= 1'b1;
                                out_bcd   <= acc_next;
                                out_err   <= err_next;
                            end else begin
                                digit_cnt <= digit_cnt + DW'(1);
                            end
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        // out_bcd/out_err stay put until the next frame loads.
                        state     <= RECV;
                        out_valid <= 1'b0;
                        bit_cnt   <= 2'd0;
                        digit_cnt <= '0;
                        sr        <= 3'd0;
                        acc       <= '0;
                        err_acc   <= 1'b0;
                    end
                end
                default: state <= RECV;
            endcase
        end
    end

endmodule

// File: tb/tb_xs3_to_bcd_rx.sv
// Bench for xs3_to_bcd_rx: directed frames plus random frames with random
// gaps, checked against an arithmetic model of Excess-3 decoding.
module tb_xs3_to_bcd_rx;

    localparam int NDIG = 2;
    localparam int W    = 4 * NDIG;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_bit = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_bcd;
    logic         out_err;
    logic         out_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    typedef logic [3:0] code_arr_t [NDIG];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    xs3_to_bcd_rx #(.NDIG(NDIG)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_bcd   (out_bcd),
        .out_err   (out_err),
        .out_ready (out_ready)
    );

    // ---------------- reference model ----------------
    // Returns {err, bcd}: each code in 3..12 contributes (code-3)*16^k,
    // anything else contributes 15*16^k and raises err.
    function automatic logic [W:0] ref_frame(input code_arr_t c);
        int unsigned val = 0;
        bit          err = 0;
        int unsigned d;
        for (int k = 0; k < NDIG; k++) begin
            if (int'(c[k]) >= 3 && int'(c[k]) <= 12) begin
                d = int'(c[k]) - 3;
            end else begin
                d   = 15;
                err = 1;
            end
            val = val + d * (1 << (4 * k));
        end
        return {err, W'(val)};
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- drivers ----------------
    // Sends one frame, optionally inserting 0..max_gap idle cycles before
    // each bit; checks that out_valid does not rise before the final bit.
    task automatic send_frame(input code_arr_t c, input int max_gap);
        for (int k = 0; k < NDIG; k++) begin
            for (int i = 0; i < 4; i++) begin
                int g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
                repeat (g) begin
                    in_valid = 1'b0;
                    in_bit   = 1'($urandom);
                    tick();
                end
                chk("in_ready_recv", 32'(in_ready), 32'd1);
                if (k == NDIG - 1 && i == 3) chk("no_early_valid", 32'(out_valid), 32'd0);
                in_valid = 1'b1;
                in_bit   = c[k][i];
                tick();
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic expect_frame(input string tag, input code_arr_t c);
        logic [W:0] r = ref_frame(c);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_bcd"},   32'(out_bcd),   32'(r[W-1:0]));
        chk({tag, "_err"},   32'(out_err),   32'(r[W]));
        chk({tag, "_rdy0"},  32'(in_ready),  32'd0);
    endtask

    task automatic release_frame(input code_arr_t c);
        logic [W:0] r = ref_frame(c);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("rel_valid", 32'(out_valid), 32'd0);
        chk("rel_ready", 32'(in_ready),  32'd1);
        chk("rel_keep",  32'(out_bcd),   32'(r[W-1:0]));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        code_arr_t c;

        // 1: reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_bcd",   32'(out_bcd),   32'd0);
        chk("rst_err",   32'(out_err),   32'd0);
        chk("rst_ready", 32'(in_ready),  32'd1);

        // 2: codes 0101, 0111 -> 42
        c = '{4'b0101, 4'b0111};
        send_frame(c, 0);
        expect_frame("f42", c);
        chk("f42_const", 32'(out_bcd), 32'h42);
        release_frame(c);

        // 3: invalid code, then boundary codes without carried error
        c = '{4'b0011, 4'b1111};
        send_frame(c, 0);
        expect_frame("ferr", c);
        chk("ferr_const", 32'({out_err, out_bcd}), 32'h1F0);
        release_frame(c);
        c = '{4'b1100, 4'b0011};
        send_frame(c, 0);
        expect_frame("f09", c);
        chk("f09_const", 32'({out_err, out_bcd}), 32'h009);
        release_frame(c);

        // 4: backpressure while in_valid keeps toggling data
        c = '{4'b0101, 4'b0111};
        send_frame(c, 0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_bit   = 1'($urandom);
            tick();
            expect_frame("stall", c);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("stall_rel_ready", 32'(in_ready), 32'd1);
        c = '{4'b1000, 4'b0110};
        send_frame(c, 0);
        expect_frame("after_stall", c);
        release_frame(c);

        // 5: frame 42 with random gaps
        c = '{4'b0101, 4'b0111};
        send_frame(c, 3);
        expect_frame("gap42", c);
        chk("gap42_const", 32'(out_bcd), 32'h42);
        release_frame(c);

        // 6: reset mid-digit, then 99
        in_valid = 1'b1;
        in_bit = 1'b1; tick();
        in_bit = 1'b0; tick();
        in_bit = 1'b1; tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_bcd",   32'(out_bcd),  32'd0);
        c = '{4'b1100, 4'b1100};
        send_frame(c, 0);
        expect_frame("f99", c);
        chk("f99_const", 32'({out_err, out_bcd}), 32'h099);
        release_frame(c);

        // random frames: mostly valid codes, random gaps and hold times
        for (int n = 0; n < 25; n++) begin
            for (int k = 0; k < NDIG; k++) begin
                c[k] = ($urandom_range(3, 0) == 0) ? 4'($urandom_range(15, 0))
                                                   : 4'($urandom_range(12, 3));
            end
            send_frame(c, int'($urandom_range(2, 0)));
            expect_frame("rnd", c);
            repeat ($urandom_range(3, 0)) begin
                in_valid = 1'($urandom);
                in_bit   = 1'($urandom);
                tick();
                expect_frame("rnd_hold", c);
            end
            in_valid = 1'b0;
            release_frame(c);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
